// File: rtl/rs_ff_pkg.sv
// -----------------------------------------------------------------------------
// rs_ff_pkg
// Shared definitions for the RS flip-flop response checker.
//   - State encoding of the checker FSM (IDLE / SYNC / CHECK).
//   - Command encoding decoded from the sampled {R,S} pair.
//   - Default counter width and the width of the settle down-counter.
// No ports; imported with "import rs_ff_pkg::*;".
// -----------------------------------------------------------------------------
package rs_ff_pkg;

    // Default width of the event / error counters.
    localparam int CNT_W_DEF = 8;

    // Settle counter holds SETTLE values up to 15.
    localparam int SETTLE_W = 4;

    // Checker FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Commands, encoded directly as the sampled {R,S} pair.
    typedef enum logic [1:0] {
        CMD_HOLD    = 2'b00,
        CMD_SET     = 2'b01,
        CMD_RESET   = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_e;

    // Decode the command driven to the flip-flop.
    function automatic cmd_e decode_cmd(input logic r, input logic s);
        return cmd_e'({r, s});
    endfunction

endpackage : rs_ff_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   Clk  in   1   clock, updates on posedge
//   clr  in   1   synchronous clear, has priority over inc
//   inc  in   1   count enable for this cycle
//   q    out  W   current count
// Parameters:
//   W    counter width
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge Clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule : sat_counter

// File: rtl/rs_ff_checker.sv
// -----------------------------------------------------------------------------
// rs_ff_checker
// Response checker for a clocked RS flip-flop. Watches the R/S commands
// driven to the flip-flop and the Q/Q_L it returns, runs a golden model
// of the expected Q, and flags Q != model or Q_L != ~Q. Counts accepted
// SET and RESET commands and mismatching cycles (all saturating).
//
// Ports:
//   Clk        in   1      clock, all state updates on posedge
//   Rst_L      in   1      synchronous reset, active-low, priority over En
//   En         in   1      1 = checking enabled, 0 = back to IDLE
//   R          in   1      reset command driven to the flip-flop
//   S          in   1      set command driven to the flip-flop
//   Q          in   1      observed flip-flop output
//   Q_L        in   1      observed complementary output
//   Err        out  1      sticky, any mismatch since reset
//   Forbidden  out  1      sticky, R=S=1 sampled while not IDLE
//   Valid      out  1      1 while in CHECK (model defined)
//   Set_Cnt    out  CNT_W  accepted SET commands
//   Reset_Cnt  out  CNT_W  accepted RESET commands
//   Err_Cnt    out  CNT_W  mismatching cycles
//   First_Err  out  CNT_W  (RS_CHECK_STAMP_EN only) stamp of first mismatch
//
// Parameters:
//   CNT_W   counter width
//   SETTLE  cycles after a SET/RESET before Q is compared (1..15)
//
// Build option:
//   RS_CHECK_STAMP_EN  adds a saturating cycle stamp counter (counts while
//                      in SYNC/CHECK) and the First_Err port.
// -----------------------------------------------------------------------------
module rs_ff_checker
    import rs_ff_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SETTLE = 1
) (
    input  logic             Clk,
    input  logic             Rst_L,
    input  logic             En,
    input  logic             R,
    input  logic             S,
    input  logic             Q,
    input  logic             Q_L,
    output logic             Err,
    output logic             Forbidden,
    output logic             Valid,
    output logic [CNT_W-1:0] Set_Cnt,
    output logic [CNT_W-1:0] Reset_Cnt,
`ifdef RS_CHECK_STAMP_EN
    output logic [CNT_W-1:0] First_Err,
`endif
    output logic [CNT_W-1:0] Err_Cnt
);

    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e                r_state;
    logic                  r_qm;        // golden model of Q
    logic [SETTLE_W-1:0]   r_settle;    // cycles left before compares resume
    logic                  r_err;
    logic                  r_forbidden;
    logic                  r_valid;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    cmd_e w_cmd;
    logic w_active;
    logic w_set_evt;
    logic w_reset_evt;
    logic w_mismatch;
    logic w_clr;

    assign w_cmd = decode_cmd(R, S);

    // Commands are only accepted while enabled and out of IDLE; En=0 wins
    // over a command sampled on the same edge.
    assign w_active    = En && (r_state != ST_IDLE);
    assign w_set_evt   = w_active && (w_cmd == CMD_SET);
    assign w_reset_evt = w_active && (w_cmd == CMD_RESET);

    // Compare uses the model value from before this edge: Q sampled now is
    // the flip-flop's answer to commands already absorbed into r_qm.
    assign w_mismatch  = En && (r_state == ST_CHECK) && (r_settle == '0) &&
                         ((Q != r_qm) || (Q_L == Q));

    // Counters clear on the same synchronous reset as the FSM.
    assign w_clr = !Rst_L;

    // ------------------------------------------------------------------
    // FSM, model and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_L) begin
            r_state     <= ST_IDLE;
            r_qm        <= 1'b0;
            r_settle    <= '0;
            r_err       <= 1'b0;
            r_forbidden <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (w_mismatch) begin
                r_err <= 1'b1;
            end

            if (!En) begin
                // Model and settle are kept; they are reloaded before the
                // next CHECK period anyway.
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SYNC;
                        r_valid <= 1'b0;
                    end

                    ST_SYNC: begin
                        case (w_cmd)
                            CMD_SET, CMD_RESET: begin
                                r_qm     <= S;
                                r_settle <= SETTLE_LD;
                                r_state  <= ST_CHECK;
                                r_valid  <= 1'b1;
                            end
                            CMD_ILLEGAL: begin
                                r_forbidden <= 1'b1;
                            end
                            default: ;
                        endcase
                    end

                    ST_CHECK: begin
                        case (w_cmd)
                            CMD_SET, CMD_RESET: begin
                                r_qm     <= S;
                                r_settle <= SETTLE_LD;
                            end
                            CMD_HOLD: begin
                                if (r_settle != '0) begin
                                    r_settle <= r_settle - 1'b1;
                                end
                            end
                            CMD_ILLEGAL: begin
                                // Flip-flop output is undefined after R=S=1,
                                // so resynchronise on the next command.
                                r_forbidden <= 1'b1;
                                r_state     <= ST_SYNC;
                                r_valid     <= 1'b0;
                            end
                            default: ;
                        endcase
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Err       = r_err;
    assign Forbidden = r_forbidden;
    assign Valid     = r_valid;

    // ------------------------------------------------------------------
    // Event and error counters
    // ------------------------------------------------------------------
    sat_counter #(.W(CNT_W)) u_set_cnt (
        .Clk (Clk),
        .clr (w_clr),
        .inc (w_set_evt),
        .q   (Set_Cnt)
    );

    sat_counter #(.W(CNT_W)) u_reset_cnt (
        .Clk (Clk),
        .clr (w_clr),
        .inc (w_reset_evt),
        .q   (Reset_Cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .Clk (Clk),
        .clr (w_clr),
        .inc (w_mismatch),
        .q   (Err_Cnt)
    );

`ifdef RS_CHECK_STAMP_EN
    // ------------------------------------------------------------------
    // Cycle stamp and first-error capture
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_stamp;
    logic [CNT_W-1:0] r_first_err;

    sat_counter #(.W(CNT_W)) u_stamp_cnt (
        .Clk (Clk),
        .clr (w_clr),
        .inc (r_state != ST_IDLE),
        .q   (w_stamp)
    );

    // r_err is still 0 on the edge of the first mismatch, which makes it
    // the "not yet captured" qualifier.
    always_ff @(posedge Clk) begin
        if (!Rst_L) begin
            r_first_err <= '0;
        end else if (w_mismatch && !r_err) begin
            r_first_err <= w_stamp;
        end
    end

    assign First_Err = r_first_err;
`endif

endmodule : rs_ff_checker

// File: tb/tb_rs_ff_checker.sv
// -----------------------------------------------------------------------------
// tb_rs_ff_checker
// Directed bench for rs_ff_checker. Unit 0 uses the default parameters,
// unit 1 uses CNT_W=4, SETTLE=3. Expected output values are queued before
// each clock edge and compared just after it.
// -----------------------------------------------------------------------------
module tb_rs_ff_checker;

    logic clk;

    // Per-unit stimulus: index 0 -> dut_a, index 1 -> dut_b.
    logic [1:0] rst_n, en, r, s, q, q_l;

    logic       a_err, a_forb, a_valid;
    logic [7:0] a_setc, a_rstc, a_errc;
    logic       b_err, b_forb, b_valid;
    logic [3:0] b_setc, b_rstc, b_errc;
`ifdef RS_CHECK_STAMP_EN
    logic [7:0] a_first;
    logic [3:0] b_first;
`endif

    rs_ff_checker dut_a (
        .Clk       (clk),
        .Rst_L     (rst_n[0]),
        .En        (en[0]),
        .R         (r[0]),
        .S         (s[0]),
        .Q         (q[0]),
        .Q_L       (q_l[0]),
        .Err       (a_err),
        .Forbidden (a_forb),
        .Valid     (a_valid),
        .Set_Cnt   (a_setc),
        .Reset_Cnt (a_rstc),
`ifdef RS_CHECK_STAMP_EN
        .First_Err (a_first),
`endif
        .Err_Cnt   (a_errc)
    );

    rs_ff_checker #(.CNT_W(4), .SETTLE(3)) dut_b (
        .Clk       (clk),
        .Rst_L     (rst_n[1]),
        .En        (en[1]),
        .R         (r[1]),
        .S         (s[1]),
        .Q         (q[1]),
        .Q_L       (q_l[1]),
        .Err       (b_err),
        .Forbidden (b_forb),
        .Valid     (b_valid),
        .Set_Cnt   (b_setc),
        .Reset_Cnt (b_rstc),
`ifdef RS_CHECK_STAMP_EN
        .First_Err (b_first),
`endif
        .Err_Cnt   (b_errc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef enum int {K_VALID, K_ERR, K_FORB, K_SETC, K_RSTC, K_ERRC, K_FIRST} kind_e;

    typedef struct {
        string       tag;
        int          u;
        kind_e       k;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic exp_out(input string tag, input int u, input kind_e k, input int val);
        exp_t e;
        e.tag = tag;
        e.u   = u;
        e.k   = k;
        e.val = 32'(val);
        sb.push_back(e);
    endtask

    task automatic exp_first(input string tag, input int val);
`ifdef RS_CHECK_STAMP_EN
        exp_out(tag, 0, K_FIRST, val);
`endif
    endtask

    function automatic logic [31:0] observe(input int u, input kind_e k);
        logic [31:0] v;
        v = 'x;
        if (u == 0) begin
            case (k)
                K_VALID: v = 32'(a_valid);
                K_ERR:   v = 32'(a_err);
                K_FORB:  v = 32'(a_forb);
                K_SETC:  v = 32'(a_setc);
                K_RSTC:  v = 32'(a_rstc);
                K_ERRC:  v = 32'(a_errc);
`ifdef RS_CHECK_STAMP_EN
                K_FIRST: v = 32'(a_first);
`endif
                default: v = 'x;
            endcase
        end else begin
            case (k)
                K_VALID: v = 32'(b_valid);
                K_ERR:   v = 32'(b_err);
                K_FORB:  v = 32'(b_forb);
                K_SETC:  v = 32'(b_setc);
                K_RSTC:  v = 32'(b_rstc);
                K_ERRC:  v = 32'(b_errc);
`ifdef RS_CHECK_STAMP_EN
                K_FIRST: v = 32'(b_first);
`endif
                default: v = 'x;
            endcase
        end
        return v;
    endfunction

    // One clock edge, then compare everything queued for it.
    task automatic tick();
        exp_t        e;
        logic [31:0] got;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = observe(e.u, e.k);
            n_tests++;
            assert (got === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, got, e.val);
            end
        end
    endtask

    task automatic set_in(input int u, input logic rst_v, input logic en_v,
                          input logic r_v, input logic s_v,
                          input logic q_v, input logic ql_v);
        rst_n[u] = rst_v;
        en[u]    = en_v;
        r[u]     = r_v;
        s[u]     = s_v;
        q[u]     = q_v;
        q_l[u]   = ql_v;
    endtask

    task automatic exp_all_zero(input string tag, input int u);
        exp_out({tag, "_valid"}, u, K_VALID, 0);
        exp_out({tag, "_err"},   u, K_ERR,   0);
        exp_out({tag, "_forb"},  u, K_FORB,  0);
        exp_out({tag, "_setc"},  u, K_SETC,  0);
        exp_out({tag, "_rstc"},  u, K_RSTC,  0);
        exp_out({tag, "_errc"},  u, K_ERRC,  0);
    endtask

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        set_in(0, 0, 0, 0, 0, 0, 1);
        set_in(1, 0, 0, 0, 0, 0, 1);

        // ---------------- unit 0: CNT_W=8, SETTLE=1 ----------------
        exp_all_zero("a_reset", 0);
        exp_all_zero("b_reset", 1);
        exp_first("a_reset_first", 0);
        tick();                                        // e1: reset

        set_in(0, 1, 1, 0, 0, 0, 1);
        exp_out("a_idle_to_sync_valid", 0, K_VALID, 0);
        tick();                                        // e2: IDLE -> SYNC

        set_in(0, 1, 1, 0, 1, 0, 1);
        exp_out("a_set_valid", 0, K_VALID, 1);
        exp_out("a_set_setc",  0, K_SETC,  1);
        exp_out("a_set_err",   0, K_ERR,   0);
        tick();                                        // e3: SET -> CHECK

        set_in(0, 1, 1, 0, 0, 1, 0);                   // flip-flop follows
        tick();                                        // e4: settle
        tick();                                        // e5
        exp_out("a_good_err",  0, K_ERR,  0);
        exp_out("a_good_errc", 0, K_ERRC, 0);
        exp_first("a_good_first", 0);
        tick();                                        // e6

        set_in(0, 1, 1, 0, 0, 0, 1);                   // Q wrong for 3 cycles
        exp_out("a_bad1_err",  0, K_ERR,  1);
        exp_out("a_bad1_errc", 0, K_ERRC, 1);
        exp_first("a_bad1_first", 4);
        tick();                                        // e7
        tick();                                        // e8
        exp_out("a_bad3_errc", 0, K_ERRC, 3);
        tick();                                        // e9

        set_in(0, 1, 1, 0, 0, 1, 0);
        exp_out("a_recover_errc", 0, K_ERRC, 3);
        tick();                                        // e10

        set_in(0, 1, 1, 0, 0, 1, 1);                   // Q_L not complementary
        exp_out("a_ql_errc", 0, K_ERRC, 4);
        exp_first("a_ql_first", 4);
        tick();                                        // e11

        set_in(0, 1, 1, 1, 0, 1, 0);                   // RESET command
        exp_out("a_reset_cmd_rstc", 0, K_RSTC, 1);
        exp_out("a_reset_cmd_errc", 0, K_ERRC, 4);
        tick();                                        // e12

        set_in(0, 1, 1, 0, 0, 0, 1);
        tick();                                        // e13
        exp_out("a_after_reset_errc", 0, K_ERRC, 4);
        tick();                                        // e14

        set_in(0, 1, 1, 1, 1, 0, 1);                   // illegal R=S=1
        exp_out("a_illegal_forb",  0, K_FORB,  1);
        exp_out("a_illegal_valid", 0, K_VALID, 0);
        tick();                                        // e15

        set_in(0, 1, 1, 0, 0, 0, 1);
        exp_out("a_sync_hold_valid", 0, K_VALID, 0);
        tick();                                        // e16

        set_in(0, 1, 1, 0, 1, 0, 1);
        exp_out("a_resync_valid", 0, K_VALID, 1);
        exp_out("a_resync_setc",  0, K_SETC,  2);
        tick();                                        // e17

        set_in(0, 1, 0, 1, 0, 1, 0);                   // En falls with RESET
        exp_out("a_en_fall_valid", 0, K_VALID, 0);
        exp_out("a_en_fall_rstc",  0, K_RSTC,  1);
        exp_out("a_en_fall_forb",  0, K_FORB,  1);
        exp_out("a_en_fall_err",   0, K_ERR,   1);
        tick();                                        // e18

        set_in(0, 1, 1, 0, 0, 1, 0);
        exp_out("a_reen_valid", 0, K_VALID, 0);
        tick();                                        // e19

        set_in(0, 1, 1, 0, 1, 1, 0);
        exp_out("a_reen_set_valid", 0, K_VALID, 1);
        exp_out("a_reen_set_setc",  0, K_SETC,  3);
        tick();                                        // e20

        set_in(0, 1, 1, 0, 0, 1, 0);
        tick();                                        // e21

        set_in(0, 0, 1, 0, 0, 1, 0);                   // reset mid-CHECK
        exp_all_zero("a_midreset", 0);
        exp_first("a_midreset_first", 0);
        tick();                                        // e22

        set_in(0, 1, 1, 0, 1, 0, 1);                   // command while IDLE
        exp_out("a_idle_cmd_valid", 0, K_VALID, 0);
        exp_out("a_idle_cmd_setc",  0, K_SETC,  0);
        tick();                                        // e23

        // ---------------- unit 1: CNT_W=4, SETTLE=3 ----------------
        set_in(0, 1, 0, 0, 0, 0, 1);
        set_in(1, 1, 1, 0, 0, 0, 1);
        exp_out("b_sync_valid", 1, K_VALID, 0);
        tick();                                        // f1: IDLE -> SYNC

        set_in(1, 1, 1, 0, 1, 0, 1);                   // 1-cycle S pulse
        exp_out("b_set_setc", 1, K_SETC, 1);
        tick();                                        // f2

        set_in(1, 1, 1, 0, 0, 0, 1);                   // Q lags 2 cycles
        exp_out("b_short_pulse_valid", 1, K_VALID, 1);
        tick();                                        // f3
        tick();                                        // f4
        set_in(1, 1, 1, 0, 0, 1, 0);
        tick();                                        // f5
        tick();                                        // f6: first compare
        exp_out("b_lag2_err",  1, K_ERR,  0);
        exp_out("b_lag2_errc", 1, K_ERRC, 0);
        tick();                                        // f7

        set_in(1, 1, 1, 1, 0, 1, 0);                   // 1-cycle R pulse
        exp_out("b_rst_rstc", 1, K_RSTC, 1);
        tick();                                        // f8

        set_in(1, 1, 1, 0, 0, 1, 0);                   // Q lags 4 cycles
        tick();                                        // f9
        tick();                                        // f10
        exp_out("b_lag4_pre_errc", 1, K_ERRC, 0);
        tick();                                        // f11
        exp_out("b_lag4_errc", 1, K_ERRC, 1);
        tick();                                        // f12
        set_in(1, 1, 1, 0, 0, 0, 1);
        exp_out("b_lag4_err",      1, K_ERR,  1);
        exp_out("b_lag4_hold_errc", 1, K_ERRC, 1);
        tick();                                        // f13

        set_in(1, 1, 1, 0, 1, 0, 1);                   // repeated SET samples
        repeat (12) tick();
        exp_out("b_set14_setc", 1, K_SETC, 14);
        tick();
        repeat (6) tick();
        exp_out("b_set_sat_setc", 1, K_SETC, 15);
        exp_out("b_set_sat_errc", 1, K_ERRC, 1);
        tick();

        set_in(1, 1, 1, 0, 0, 0, 1);                   // Q stuck low vs Qm=1
        repeat (3) tick();
        exp_out("b_err_first_cmp_errc", 1, K_ERRC, 2);
        tick();
        repeat (15) tick();
        exp_out("b_err_sat_errc", 1, K_ERRC, 15);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rs_ff_checker
